// File: rtl/sram_router_top_if.sv
`default_nettype none
// ==========================================================================
// sram_router_if : write port, geometry config and routed output stream
// Revision: 1.0
// ==========================================================================
interface sram_router_if #(
  parameter int SRAM_DATA_WIDTH = 64,
  parameter int ADDR_WIDTH      = 8
);
  logic                       i_reg_clear;
  logic [1:0]                 i_p_mode;
  logic [SRAM_DATA_WIDTH-1:0] i_data_in;
  logic [ADDR_WIDTH-1:0]      i_write_addr;
  logic [1:0]                 i_sram_select;
  logic                       i_write_en;
  logic                       i_route_en;
  logic [ADDR_WIDTH-1:0]      i_i_start_addr;
  logic [ADDR_WIDTH-1:0]      i_i_addr_end;
  logic [ADDR_WIDTH-1:0]      i_i_size;
  logic [ADDR_WIDTH-1:0]      i_o_size;
  logic [ADDR_WIDTH-1:0]      i_stride;
  logic [ADDR_WIDTH-1:0]      i_w_start_addr;
  logic [ADDR_WIDTH-1:0]      i_w_addr_offset;
  logic [ADDR_WIDTH-1:0]      i_route_size;
  logic [SRAM_DATA_WIDTH-1:0] o_i_data;
  logic [SRAM_DATA_WIDTH-1:0] o_w_data;
  logic                       o_valid;
  logic                       o_win_last;
  logic [1:0]                 o_p_mode;
  logic                       o_done;

  modport master (
    output i_reg_clear, i_p_mode, i_data_in, i_write_addr, i_sram_select,
           i_write_en, i_route_en, i_i_start_addr, i_i_addr_end, i_i_size,
           i_o_size, i_stride, i_w_start_addr, i_w_addr_offset, i_route_size,
    input  o_i_data, o_w_data, o_valid, o_win_last, o_p_mode, o_done
  );

  modport slave (
    input  i_reg_clear, i_p_mode, i_data_in, i_write_addr, i_sram_select,
           i_write_en, i_route_en, i_i_start_addr, i_i_addr_end, i_i_size,
           i_o_size, i_stride, i_w_start_addr, i_w_addr_offset, i_route_size,
    output o_i_data, o_w_data, o_valid, o_win_last, o_p_mode, o_done
  );
endinterface
`default_nettype wire

// File: rtl/sram_router_top.sv
`default_nettype none
// ==========================================================================
// sram_router_top : weight/input buffers streaming conv windows to the array
// Revision: 1.0
// ==========================================================================
module sram_router_top #(
  parameter int SRAM_DATA_WIDTH = 64,
  parameter int ADDR_WIDTH      = 8
) (
  input  wire logic     i_clk,
  input  wire logic     i_nrst,
  sram_router_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0]      addr_t;
  typedef logic [SRAM_DATA_WIDTH-1:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUTE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t state, state_nx;

  word_t weight_mem [DEPTH];
  word_t input_mem  [DEPTH];
  word_t i_q, w_q;

  addr_t cfg_i_end, cfg_i_size, cfg_o_last, cfg_stride;
  addr_t cfg_w_start, cfg_w_off, cfg_n_last, cfg_k_last, cfg_row_step;
  addr_t oy, ox, n, kx, row_base, win_base, krow_base, w_addr;
  logic [1:0] p_mode_q;

  logic  s1_valid, s1_last, s1_pad;
  logic  out_valid, out_last;
  word_t out_i_data, out_w_data;

  addr_t k_calc, rd_i_addr;
  logic  clear, route_en, start, issue, zero_geom;
  logic  win_end, row_end, last_issue;

  assign clear      = bus.i_reg_clear;
  assign route_en   = bus.i_route_en;
  assign start      = (state == ST_IDLE) && route_en && !clear;
  assign issue      = (state == ST_ROUTE) && route_en && !clear;
  assign zero_geom  = (bus.i_o_size == '0) || (bus.i_route_size == '0);
  assign k_calc     = bus.i_i_size - addr_t'((bus.i_o_size - addr_t'(1)) * bus.i_stride);
  assign rd_i_addr  = krow_base + kx;
  assign win_end    = (n == cfg_n_last);
  assign row_end    = (ox == cfg_o_last);
  assign last_issue = win_end && row_end && (oy == cfg_o_last);

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) state <= ST_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (clear) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (route_en) state_nx = zero_geom ? ST_DONE : ST_ROUTE;
        ST_ROUTE: if (!route_en) state_nx = ST_IDLE;
                  else if (last_issue) state_nx = ST_DRAIN;
        // Last word is on the outputs once stage 1 has emptied.
        ST_DRAIN: if (!route_en) state_nx = ST_IDLE;
                  else if (out_valid && !s1_valid) state_nx = ST_DONE;
        ST_DONE:  if (!route_en) state_nx = ST_IDLE;
        default:  state_nx = ST_IDLE;
      endcase
    end
  end

  // Window walk: row_base/win_base/krow_base replace the multiplies of the
  // address formula with running sums; kx wraps at k so ky never needs a divider.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      {cfg_i_end, cfg_i_size, cfg_o_last, cfg_stride}             <= '0;
      {cfg_w_start, cfg_w_off, cfg_n_last, cfg_k_last, cfg_row_step} <= '0;
      {oy, ox, n, kx, row_base, win_base, krow_base, w_addr}      <= '0;
      p_mode_q <= 2'b00;
    end else if (clear) begin
      {oy, ox, n, kx, row_base, win_base, krow_base, w_addr} <= '0;
      p_mode_q <= 2'b00;
    end else if (start) begin
      cfg_i_end    <= bus.i_i_addr_end;
      cfg_i_size   <= bus.i_i_size;
      cfg_o_last   <= bus.i_o_size - addr_t'(1);
      cfg_stride   <= bus.i_stride;
      cfg_w_start  <= bus.i_w_start_addr;
      cfg_w_off    <= bus.i_w_addr_offset;
      cfg_n_last   <= bus.i_route_size - addr_t'(1);
      cfg_k_last   <= k_calc - addr_t'(1);
      cfg_row_step <= addr_t'(bus.i_stride * bus.i_i_size);
      oy        <= '0;
      ox        <= '0;
      n         <= '0;
      kx        <= '0;
      row_base  <= bus.i_i_start_addr;
      win_base  <= bus.i_i_start_addr;
      krow_base <= bus.i_i_start_addr;
      w_addr    <= bus.i_w_start_addr;
      p_mode_q  <= (bus.i_p_mode == 2'b11) ? 2'b00 : bus.i_p_mode;
    end else if (issue) begin
      if (win_end) begin
        n      <= '0;
        kx     <= '0;
        w_addr <= cfg_w_start;
        if (row_end) begin
          ox        <= '0;
          oy        <= oy + addr_t'(1);
          row_base  <= row_base + cfg_row_step;
          win_base  <= row_base + cfg_row_step;
          krow_base <= row_base + cfg_row_step;
        end else begin
          ox        <= ox + addr_t'(1);
          win_base  <= win_base + cfg_stride;
          krow_base <= win_base + cfg_stride;
        end
      end else begin
        n      <= n + addr_t'(1);
        w_addr <= w_addr + cfg_w_off;
        if (kx == cfg_k_last) begin
          kx        <= '0;
          krow_base <= krow_base + cfg_i_size;
        end else begin
          kx <= kx + addr_t'(1);
        end
      end
    end
  end

  // Buffers: read and write in one process gives old data on a collision.
  always_ff @(posedge i_clk) begin
    if (bus.i_write_en && (bus.i_sram_select == 2'd0))
      weight_mem[bus.i_write_addr] <= bus.i_data_in;
    if (bus.i_write_en && (bus.i_sram_select == 2'd1))
      input_mem[bus.i_write_addr] <= bus.i_data_in;
    i_q <= input_mem[rd_i_addr];
    w_q <= weight_mem[w_addr];
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      s1_valid   <= 1'b0;
      s1_last    <= 1'b0;
      s1_pad     <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_i_data <= '0;
      out_w_data <= '0;
    end else if (clear) begin
      s1_valid   <= 1'b0;
      s1_last    <= 1'b0;
      s1_pad     <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_i_data <= '0;
      out_w_data <= '0;
    end else begin
      s1_valid   <= issue;
      s1_last    <= issue && win_end;
      s1_pad     <= rd_i_addr > cfg_i_end;
      out_valid  <= s1_valid && route_en;
      out_last   <= s1_valid && route_en && s1_last;
      out_i_data <= (s1_valid && route_en && !s1_pad) ? i_q : '0;
      out_w_data <= (s1_valid && route_en) ? w_q : '0;
    end
  end

  assign bus.o_i_data   = out_i_data;
  assign bus.o_w_data   = out_w_data;
  assign bus.o_valid    = out_valid;
  assign bus.o_win_last = out_last;
  assign bus.o_p_mode   = p_mode_q;
  assign bus.o_done     = (state == ST_DONE);
endmodule
`default_nettype wire

// File: tb/tb_sram_router_top.sv
`default_nettype none
// ==========================================================================
// tb_sram_router_top : random and directed routing runs against a window model
// Revision: 1.0
// ==========================================================================
module tb_sram_router_top;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  sram_router_if bus ();
  sram_router_top dut (.i_clk(clk), .i_nrst(nrst), .bus(bus));

  typedef struct {
    int isz, osz, stride, istart, iend, wstart, woff, rsz, pmode;
  } cfg_t;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] ref_w [256];
  logic [63:0] ref_i [256];
  logic [63:0] exp_i [$];
  logic [63:0] exp_w [$];
  logic        exp_last [$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic write_word(input int sel, input int addr, input logic [63:0] d);
    bus.i_sram_select = 2'(sel);
    bus.i_write_addr  = 8'(addr);
    bus.i_data_in     = d;
    bus.i_write_en    = 1'b1;
    @(negedge clk);
    bus.i_write_en    = 1'b0;
    if (sel == 0) ref_w[addr] = d;
    else if (sel == 1) ref_i[addr] = d;
  endtask

  // Expected stream straight from the address formulas, window by window.
  task automatic build_expected(input cfg_t c);
    int k, ky, kx, a;
    exp_i.delete();
    exp_w.delete();
    exp_last.delete();
    k = (c.isz - (c.osz - 1) * c.stride) & 255;
    for (int oy = 0; oy < c.osz; oy++)
      for (int ox = 0; ox < c.osz; ox++)
        for (int n = 0; n < c.rsz; n++) begin
          ky = n / k;
          kx = n % k;
          a  = (c.istart + (oy * c.stride + ky) * c.isz + ox * c.stride + kx) & 255;
          exp_i.push_back((a > c.iend) ? 64'd0 : ref_i[a]);
          exp_w.push_back(ref_w[(c.wstart + n * c.woff) & 255]);
          exp_last.push_back(n == c.rsz - 1);
        end
  endtask

  task automatic apply_cfg(input cfg_t c);
    bus.i_i_size        = 8'(c.isz);
    bus.i_o_size        = 8'(c.osz);
    bus.i_stride        = 8'(c.stride);
    bus.i_i_start_addr  = 8'(c.istart);
    bus.i_i_addr_end    = 8'(c.iend);
    bus.i_w_start_addr  = 8'(c.wstart);
    bus.i_w_addr_offset = 8'(c.woff);
    bus.i_route_size    = 8'(c.rsz);
    bus.i_p_mode        = 2'(c.pmode);
  endtask

  // mode 0: full run; 1: drop route_en after stop_after words; 2: pulse clear.
  task automatic run_route(input cfg_t c, input int stop_after, input int mode, input string nm);
    int nwords;
    logic [1:0] pm;
    pm = (c.pmode == 3) ? 2'd0 : 2'(c.pmode);
    build_expected(c);
    apply_cfg(c);
    bus.i_route_en = 1'b1;
    nwords = (mode == 0) ? exp_i.size() : stop_after;
    @(negedge clk);
    check({nm, ".lat1"}, 64'(bus.o_valid), 64'd0);
    @(negedge clk);
    check({nm, ".lat2"}, 64'(bus.o_valid), 64'd0);
    for (int i = 0; i < nwords; i++) begin
      @(negedge clk);
      check($sformatf("%s.valid[%0d]", nm, i), 64'(bus.o_valid), 64'd1);
      check($sformatf("%s.idata[%0d]", nm, i), bus.o_i_data, exp_i[i]);
      check($sformatf("%s.wdata[%0d]", nm, i), bus.o_w_data, exp_w[i]);
      check($sformatf("%s.last[%0d]", nm, i), 64'(bus.o_win_last), 64'(exp_last[i]));
      check($sformatf("%s.pmode[%0d]", nm, i), 64'(bus.o_p_mode), 64'(pm));
    end
    if (mode == 0) begin
      @(negedge clk);
      check({nm, ".end_valid"}, 64'(bus.o_valid), 64'd0);
      check({nm, ".done"}, 64'(bus.o_done), 64'd1);
      @(negedge clk);
      check({nm, ".done_hold"}, 64'(bus.o_done), 64'd1);
      bus.i_route_en = 1'b0;
      @(negedge clk);
      check({nm, ".done_drop"}, 64'(bus.o_done), 64'd0);
    end else begin
      if (mode == 1) bus.i_route_en = 1'b0;
      else           bus.i_reg_clear = 1'b1;
      @(negedge clk);
      check({nm, ".abort_valid"}, 64'(bus.o_valid), 64'd0);
      check({nm, ".abort_last"}, 64'(bus.o_win_last), 64'd0);
      check({nm, ".abort_done"}, 64'(bus.o_done), 64'd0);
      if (mode == 2) check({nm, ".clr_idata"}, bus.o_i_data, 64'd0);
      bus.i_reg_clear = 1'b0;
      bus.i_route_en  = 1'b0;
      @(negedge clk);
      check({nm, ".idle_valid"}, 64'(bus.o_valid), 64'd0);
    end
  endtask

  task automatic random_cfg(output cfg_t c);
    int maxo, k;
    c.isz    = $urandom_range(3, 8);
    c.stride = $urandom_range(1, 2);
    maxo     = (c.isz - 1) / c.stride + 1;
    c.osz    = $urandom_range(1, maxo);
    k        = c.isz - (c.osz - 1) * c.stride;
    c.rsz    = k * k;
    c.istart = $urandom_range(0, 255);
    c.iend   = $urandom_range(0, 255);
    c.wstart = $urandom_range(0, 255);
    c.woff   = $urandom_range(0, 255);
    c.pmode  = $urandom_range(0, 3);
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, ".valid"}, 64'(bus.o_valid), 64'd0);
    check({nm, ".idata"}, bus.o_i_data, 64'd0);
    check({nm, ".wdata"}, bus.o_w_data, 64'd0);
    check({nm, ".last"}, 64'(bus.o_win_last), 64'd0);
    check({nm, ".pmode"}, 64'(bus.o_p_mode), 64'd0);
    check({nm, ".done"}, 64'(bus.o_done), 64'd0);
  endtask

  initial begin
    cfg_t ca, cb, cc, cr;
    bus.i_reg_clear = 1'b0;
    bus.i_p_mode = 2'd0;
    bus.i_data_in = '0;
    bus.i_write_addr = '0;
    bus.i_sram_select = 2'd3;
    bus.i_write_en = 1'b0;
    bus.i_route_en = 1'b0;
    ca = '{isz:5, osz:3, stride:1, istart:0, iend:24, wstart:0, woff:1, rsz:9, pmode:1};
    apply_cfg(ca);
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    nrst = 1'b1;
    @(negedge clk);

    for (int a = 0; a < 25; a++) write_word(0, a, 64'(a));
    for (int a = 0; a < 25; a++) write_word(1, a, 64'(a));
    write_word(2, 3, 64'hDEAD_BEEF);

    run_route(ca, 0, 0, "cfgA");
    cb = '{isz:5, osz:2, stride:2, istart:0, iend:24, wstart:0, woff:1, rsz:9, pmode:2};
    run_route(cb, 0, 0, "cfgB");
    cc = ca;
    cc.iend = 20;
    cc.pmode = 3;
    run_route(cc, 0, 0, "cfgPad");

    run_route(ca, 20, 1, "drop");
    run_route(ca, 0, 0, "rerunDrop");
    run_route(ca, 13, 2, "clear");
    run_route(ca, 0, 0, "rerunClear");

    apply_cfg(ca);
    bus.i_route_en = 1'b1;
    repeat (10) @(negedge clk);
    #2 nrst = 1'b0;
    #1 check_all_zero("asyncRst");
    @(negedge clk);
    bus.i_route_en = 1'b0;
    nrst = 1'b1;
    @(negedge clk);
    for (int a = 0; a < 256; a++) write_word(0, a, {$urandom, $urandom});
    for (int a = 0; a < 256; a++) write_word(1, a, {$urandom, $urandom});
    run_route(ca, 0, 0, "postRst");

    for (int t = 0; t < 8; t++) begin
      random_cfg(cr);
      run_route(cr, 0, 0, $sformatf("rnd%0d", t));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
